// File: rtl/color_combiner_stage.sv
// Texture-environment combine stage wrapped around an external 2-cycle signed color mixer.
// Builds signed mixer operands per mode, tracks valid/tag through the mixer, then clamps the result.
module color_combiner_stage #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int TAG_WIDTH     = 16
) (
  input  logic                             aclk,
  input  logic                             reset,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [4*CHANNEL_WIDTH-1:0]       s_primary,
  input  logic [4*CHANNEL_WIDTH-1:0]       s_texture,
  input  logic [4*CHANNEL_WIDTH-1:0]       s_constant,
  input  logic [4*CHANNEL_WIDTH-1:0]       s_previous,
  input  logic [2:0]                       s_mode,
  input  logic [1:0]                       s_src0,
  input  logic [1:0]                       s_src1,
  input  logic [1:0]                       s_src2,
  input  logic [TAG_WIDTH-1:0]             s_tag,
  output logic                             mixer_ce,
  output logic [4*(CHANNEL_WIDTH+1)-1:0]   mixer_colorA,
  output logic [4*(CHANNEL_WIDTH+1)-1:0]   mixer_colorB,
  output logic [4*(CHANNEL_WIDTH+1)-1:0]   mixer_colorC,
  output logic [4*(CHANNEL_WIDTH+1)-1:0]   mixer_colorD,
  input  logic [4*(CHANNEL_WIDTH+1)-1:0]   mixer_mixed,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [4*CHANNEL_WIDTH-1:0]       m_color,
  output logic [TAG_WIDTH-1:0]             m_tag
);

  localparam int CW  = CHANNEL_WIDTH;
  localparam int SPW = CHANNEL_WIDTH + 1;

  typedef enum logic [2:0] {
    MODE_REPLACE     = 3'd0,
    MODE_MODULATE    = 3'd1,
    MODE_ADD         = 3'd2,
    MODE_SUBTRACT    = 3'd3,
    MODE_INTERPOLATE = 3'd4
  } mode_t;

  logic                 ce;
  logic [4*CW-1:0]      arg0, arg1, arg2;
  logic [4*SPW-1:0]     op_a, op_b, op_c, op_d;
  logic [4*CW-1:0]      clamped;
  logic                 v1, v2, v3;
  logic [TAG_WIDTH-1:0] t1, t2, t3;

  // The whole pipeline, including the external mixer, advances only when the output slot can move.
  assign ce       = !m_valid || m_ready;
  assign s_ready  = ce;
  assign mixer_ce = ce;

  function automatic logic [4*CW-1:0] pick_src(input logic [1:0] src,
                                               input logic [4*CW-1:0] p, t, c, v);
    case (src)
      2'd0:    pick_src = p;
      2'd1:    pick_src = t;
      2'd2:    pick_src = c;
      default: pick_src = v;
    endcase
  endfunction

  assign arg0 = pick_src(s_src0, s_primary, s_texture, s_constant, s_previous);
  assign arg1 = pick_src(s_src1, s_primary, s_texture, s_constant, s_previous);
  assign arg2 = pick_src(s_src2, s_primary, s_texture, s_constant, s_previous);

  // Unsigned args are zero-extended to signed operands; negation fits since -ONE is representable.
  always_comb begin
    logic [SPW-1:0] a0, a1, a2, one;
    op_a = '0;
    op_b = '0;
    op_c = '0;
    op_d = '0;
    a0   = '0;
    a1   = '0;
    a2   = '0;
    one  = {1'b0, {CW{1'b1}}};
    for (int i = 0; i < 4; i++) begin
      a0 = {1'b0, arg0[i*CW +: CW]};
      a1 = {1'b0, arg1[i*CW +: CW]};
      a2 = {1'b0, arg2[i*CW +: CW]};
      op_a[i*SPW +: SPW] = a0;
      case (s_mode)
        MODE_MODULATE: begin
          op_b[i*SPW +: SPW] = a1;
        end
        MODE_ADD: begin
          op_b[i*SPW +: SPW] = one;
          op_c[i*SPW +: SPW] = a1;
          op_d[i*SPW +: SPW] = one;
        end
        MODE_SUBTRACT: begin
          op_b[i*SPW +: SPW] = one;
          op_c[i*SPW +: SPW] = {SPW{1'b0}} - a1;
          op_d[i*SPW +: SPW] = one;
        end
        MODE_INTERPOLATE: begin
          op_b[i*SPW +: SPW] = a2;
          op_c[i*SPW +: SPW] = a1;
          op_d[i*SPW +: SPW] = one - a2;
        end
        default: begin
          op_b[i*SPW +: SPW] = one;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      mixer_colorA <= '0;
      mixer_colorB <= '0;
      mixer_colorC <= '0;
      mixer_colorD <= '0;
      v1           <= 1'b0;
      t1           <= '0;
    end else if (ce) begin
      v1 <= s_valid;
      if (s_valid) begin
        mixer_colorA <= op_a;
        mixer_colorB <= op_b;
        mixer_colorC <= op_c;
        mixer_colorD <= op_d;
        t1           <= s_tag;
      end
    end
  end

  // Valid/tag shadow of the two mixer register stages.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      v2 <= 1'b0;
      v3 <= 1'b0;
      t2 <= '0;
      t3 <= '0;
    end else if (ce) begin
      v2 <= v1;
      v3 <= v2;
      t2 <= t1;
      t3 <= t2;
    end
  end

  always_comb begin
    logic [SPW-1:0] ch;
    clamped = '0;
    ch      = '0;
    for (int i = 0; i < 4; i++) begin
      ch = mixer_mixed[i*SPW +: SPW];
      clamped[i*CW +: CW] = ch[SPW-1] ? {CW{1'b0}} : ch[CW-1:0];
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_color <= '0;
      m_tag   <= '0;
    end else if (ce) begin
      m_valid <= v3;
      if (v3) begin
        m_color <= clamped;
        m_tag   <= t3;
      end
    end
  end

endmodule

// File: tb/tb_color_combiner_stage.sv
// Bench for color_combiner_stage: models the external 2-cycle mixer and checks results
// against a per-channel arithmetic reference of the combine modes.
module tb_color_combiner_stage;

  logic        aclk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_primary, s_texture, s_constant, s_previous;
  logic [2:0]  s_mode;
  logic [1:0]  s_src0, s_src1, s_src2;
  logic [15:0] s_tag;
  logic        mixer_ce;
  logic [35:0] mixer_colorA, mixer_colorB, mixer_colorC, mixer_colorD;
  logic [35:0] mixer_mixed;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_color;
  logic [15:0] m_tag;

  int checks = 0;
  int errors = 0;
  logic [47:0] sb[$];

  always #5 aclk = ~aclk;

  color_combiner_stage #(.CHANNEL_WIDTH(8), .TAG_WIDTH(16)) dut (
    .aclk(aclk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_primary(s_primary), .s_texture(s_texture), .s_constant(s_constant), .s_previous(s_previous),
    .s_mode(s_mode), .s_src0(s_src0), .s_src1(s_src1), .s_src2(s_src2), .s_tag(s_tag),
    .mixer_ce(mixer_ce),
    .mixer_colorA(mixer_colorA), .mixer_colorB(mixer_colorB),
    .mixer_colorC(mixer_colorC), .mixer_colorD(mixer_colorD),
    .mixer_mixed(mixer_mixed),
    .m_valid(m_valid), .m_ready(m_ready), .m_color(m_color), .m_tag(m_tag)
  );

  // Mixer stand-in: (A*B + C*D + ONE) >>> 8 saturated to signed 9 bits, two ce-gated registers deep.
  function automatic logic [35:0] mixFn(input logic [35:0] a, b, c, d);
    logic [35:0] res;
    logic signed [8:0] ta, tb, tc, td;
    int r;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      ta = a[i*9 +: 9];
      tb = b[i*9 +: 9];
      tc = c[i*9 +: 9];
      td = d[i*9 +: 9];
      r = (int'(ta) * int'(tb) + int'(tc) * int'(td) + 255) >>> 8;
      if (r > 255) r = 255;
      if (r < -256) r = -256;
      res[i*9 +: 9] = r[8:0];
    end
    return res;
  endfunction

  logic [35:0] mixS2 = '0;
  logic [35:0] mixS3 = '0;
  always @(posedge aclk) begin
    if (mixer_ce) begin
      mixS2 <= mixFn(mixer_colorA, mixer_colorB, mixer_colorC, mixer_colorD);
      mixS3 <= mixS2;
    end
  end
  assign mixer_mixed = mixS3;

  function automatic int argOf(input logic [1:0] src, input int ch,
                               input logic [31:0] p, t, c, v);
    case (src)
      2'd0:    return int'(p[ch*8 +: 8]);
      2'd1:    return int'(t[ch*8 +: 8]);
      2'd2:    return int'(c[ch*8 +: 8]);
      default: return int'(v[ch*8 +: 8]);
    endcase
  endfunction

  // Reference: the mode's blend in plain integer math, rounded by +ONE then /256, clamped to 0..255.
  function automatic logic [31:0] refColor(input logic [2:0] mode, input logic [1:0] s0, s1, s2,
                                           input logic [31:0] p, t, c, v);
    logic [31:0] res;
    int x0, x1, x2, prod, r;
    res = '0;
    for (int ch = 0; ch < 4; ch++) begin
      x0 = argOf(s0, ch, p, t, c, v);
      x1 = argOf(s1, ch, p, t, c, v);
      x2 = argOf(s2, ch, p, t, c, v);
      case (mode)
        3'd1:    prod = x0 * x1;
        3'd2:    prod = 255 * (x0 + x1);
        3'd3:    prod = 255 * (x0 - x1);
        3'd4:    prod = x0 * x2 + x1 * (255 - x2);
        default: prod = 255 * x0;
      endcase
      r = (prod + 255) >>> 8;
      if (r < 0) r = 0;
      if (r > 255) r = 255;
      res[ch*8 +: 8] = r[7:0];
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] observed, input logic [47:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] mode, input logic [1:0] s0, s1, s2,
                               input logic [31:0] p, t, c, v, input logic [15:0] tag);
    s_mode     = mode;
    s_src0     = s0;
    s_src1     = s1;
    s_src2     = s2;
    s_primary  = p;
    s_texture  = t;
    s_constant = c;
    s_previous = v;
    s_tag      = tag;
  endtask

  task automatic applyRandom(input logic [15:0] tag);
    applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, tag);
  endtask

  function automatic logic [47:0] expectedNow();
    return {s_tag, refColor(s_mode, s_src0, s_src1, s_src2, s_primary, s_texture, s_constant, s_previous)};
  endfunction

  // One fragment through an empty pipeline with m_ready held high.
  task automatic runSingle(input string name, input logic [2:0] mode, input logic [1:0] s0, s1, s2,
                           input logic [31:0] p, t, c, v, input logic [15:0] tag,
                           input logic [31:0] expColor);
    int lat;
    @(negedge aclk);
    applyStimulus(mode, s0, s1, s2, p, t, c, v, tag);
    s_valid = 1'b1;
    #1 checkOutput({name, "_sready"}, 48'(s_ready), 48'd1);
    @(negedge aclk);
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 20) begin
      @(negedge aclk);
      lat++;
    end
    checkOutput({name, "_latency"}, 48'(lat), 48'd4);
    checkOutput({name, "_color"}, 48'(m_color), 48'(expColor));
    checkOutput({name, "_tag"}, 48'(m_tag), 48'(tag));
  endtask

  initial begin
    logic [47:0] e;
    logic [31:0] holdColor;
    logic [15:0] holdTag;
    int nextTag, outCount, sent, cyc, seen;

    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    applyStimulus(3'd0, 2'd0, 2'd0, 2'd0, '0, '0, '0, '0, '0);
    repeat (2) @(negedge aclk);
    #1;
    checkOutput("rst_m_valid", 48'(m_valid), 48'd0);
    checkOutput("rst_m_color", 48'(m_color), 48'd0);
    checkOutput("rst_m_tag", 48'(m_tag), 48'd0);
    checkOutput("rst_colorA", 48'(mixer_colorA), 48'd0);
    @(negedge aclk);
    reset = 1'b0;
    #1 checkOutput("rst_s_ready", 48'(s_ready), 48'd1);

    runSingle("modulate", 3'd1, 2'd1, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h80808080, 32'h0, 32'h0, 16'h0001, 32'h80808080);
    runSingle("add_sat", 3'd2, 2'd2, 2'd3, 2'd0, 32'h0, 32'h0, 32'hC0C0C0C0, 32'h80808080, 16'h0002, 32'hFFFFFFFF);
    runSingle("sub", 3'd3, 2'd1, 2'd0, 2'd0, 32'h40404040, 32'h80808080, 32'h0, 32'h0, 16'h0003, 32'h40404040);
    runSingle("sub_neg", 3'd3, 2'd1, 2'd0, 2'd0, 32'h80808080, 32'h40404040, 32'h0, 32'h0, 16'h0004, 32'h00000000);
    runSingle("interp", 3'd4, 2'd0, 2'd1, 2'd2, 32'hFFFFFFFF, 32'h00000000, 32'h80808080, 32'h0, 16'h0005, 32'h80808080);
    runSingle("replace", 3'd0, 2'd3, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h5A5A5A5A, 16'h0006, 32'h5A5A5A5A);
    runSingle("mode7", 3'd7, 2'd2, 2'd1, 2'd0, 32'h0, 32'hFFFFFFFF, 32'h11223344, 32'h0, 16'h0007, 32'h11223344);

    // Tags 0..7 back to back with a five-cycle downstream stall in the middle.
    sb.delete();
    nextTag  = 0;
    outCount = 0;
    holdColor = '0;
    holdTag   = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      m_ready = !(c >= 6 && c < 11);
      if (nextTag < 8) begin
        applyRandom(16'(nextTag));
        s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (c >= 6 && c < 11) begin
        checkOutput("stall_s_ready", 48'(s_ready), 48'd0);
        checkOutput("stall_m_valid", 48'(m_valid), 48'd1);
      end
      if (c == 6) begin
        holdColor = m_color;
        holdTag   = m_tag;
      end else if (c > 6 && c < 11) begin
        checkOutput("stall_color_hold", 48'(m_color), 48'(holdColor));
        checkOutput("stall_tag_hold", 48'(m_tag), 48'(holdTag));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checkOutput("stall_unexpected", 48'd1, 48'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("stall_tag", 48'(m_tag), 48'(e[47:32]));
          checkOutput("stall_color", 48'(m_color), 48'(e[31:0]));
        end
        outCount++;
      end
      if (s_valid && s_ready) begin
        sb.push_back(expectedNow());
        nextTag++;
      end
    end
    checkOutput("stall_out_count", 48'(outCount), 48'd8);

    // Three fragments in flight, output stalled, then reset pulsed between clock edges.
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      applyRandom(16'(100 + c));
      s_valid = 1'b1;
    end
    @(negedge aclk);
    s_valid = 1'b0;
    @(negedge aclk);
    m_ready = 1'b0;
    #1 checkOutput("rstmid_pre_valid", 48'(m_valid), 48'd1);
    #1 reset = 1'b1;
    #1 checkOutput("rstmid_drop", 48'(m_valid), 48'd0);
    @(negedge aclk);
    reset   = 1'b0;
    m_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      #1 if (m_valid) seen++;
    end
    checkOutput("rstmid_no_stale", 48'(seen), 48'd0);
    runSingle("rstmid_next", 3'd1, 2'd0, 2'd1, 2'd0, 32'h10203040, 32'hFF80FF40, 32'h0, 32'h0, 16'h0BEE,
              refColor(3'd1, 2'd0, 2'd1, 2'd0, 32'h10203040, 32'hFF80FF40, 32'h0, 32'h0));

    // Random valid/ready traffic against the scoreboard.
    sb.delete();
    sent = 0;
    cyc  = 0;
    while ((sent < 10000 || sb.size() > 0) && cyc < 60000) begin
      @(negedge aclk);
      cyc++;
      m_ready = ($urandom_range(0, 9) < 7);
      if (sent < 10000 && $urandom_range(0, 9) < 7) begin
        applyRandom(16'(sent));
        s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checkOutput("rnd_unexpected", 48'd1, 48'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rnd_tag", 48'(m_tag), 48'(e[47:32]));
          checkOutput("rnd_color", 48'(m_color), 48'(e[31:0]));
        end
      end
      if (s_valid && s_ready) begin
        sb.push_back(expectedNow());
        sent++;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    checkOutput("rnd_sent", 48'(sent), 48'd10000);
    checkOutput("rnd_drained", 48'(sb.size()), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
